rom_streamer: RTL and testbench

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer.sv | 131 +++++++++++++
 tb/tb_rom_streamer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_streamer.sv
// Streams a run of characters from an external combinational ROM through a
// valid/ready handshake. Optional STREAM_LOOP_EN adds a `loop` input that replays the stream.
module rom_streamer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
`ifdef STREAM_LOOP_EN
   input  logic              loop,
`endif
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] char_out,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   char_q, char_d;
`ifdef STREAM_LOOP_EN
   // Stream parameters kept so a looping stream can be replayed from DONE.
   logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
   logic [ADDR_W:0]     base_cnt_q, base_cnt_d;
   logic                loop_q, loop_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      char_d  = char_q;
`ifdef STREAM_LOOP_EN
      base_addr_d = base_addr_q;
      base_cnt_d  = base_cnt_q;
      loop_d      = loop_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = start_addr;
               cnt_d   = (len == '0) ? FULL_CNT : len;
`ifdef STREAM_LOOP_EN
               base_addr_d = start_addr;
               base_cnt_d  = (len == '0) ? FULL_CNT : len;
`endif
               state_d = FETCH;
            end
         end
         FETCH: begin
            char_d  = rom_data;
            state_d = abort ? IDLE : SEND;
         end
         SEND: begin
            // abort wins over a handshake in the same cycle
            if (abort) begin
               state_d = IDLE;
            end else if (char_ready) begin
               if (cnt_q > ONE_CNT) begin
                  cnt_d   = cnt_q - ONE_CNT;
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = FETCH;
               end else begin
`ifdef STREAM_LOOP_EN
                  loop_d = loop;
`endif
                  state_d = DONE;
               end
            end
         end
         DONE: begin
`ifdef STREAM_LOOP_EN
            if (loop_q) begin
               addr_d  = base_addr_q;
               cnt_d   = base_cnt_q;
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         char_q  <= '0;
`ifdef STREAM_LOOP_EN
         base_addr_q <= '0;
         base_cnt_q  <= '0;
         loop_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         char_q  <= char_d;
`ifdef STREAM_LOOP_EN
         base_addr_q <= base_addr_d;
         base_cnt_q  <= base_cnt_d;
         loop_q      <= loop_d;
`endif
      end
   end

   assign rom_addr   = addr_q;
   assign char_out   = char_q;
   assign char_valid = (state_q == SEND);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer against a 16-entry ROM "SPATARUIONESCUB",0x38.
module tb_rom_streamer;

   logic       clk = 1'b0;
   logic       rst, start, abort, char_ready;
   logic [3:0] start_addr, rom_addr;
   logic [4:0] len;
   logic [7:0] rom_data, char_out;
   logic       char_valid, busy, done;
`ifdef STREAM_LOOP_EN
   logic       loop;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] got[$];
   logic [3:0] adrs[$];
   int n_done, hs_cyc, done_cyc, end_cyc;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [3:0] a);
      case (a)
         4'd0: return 8'h53;  4'd1: return 8'h50;  4'd2: return 8'h41;  4'd3: return 8'h54;
         4'd4: return 8'h41;  4'd5: return 8'h52;  4'd6: return 8'h55;  4'd7: return 8'h49;
         4'd8: return 8'h4F;  4'd9: return 8'h4E;  4'd10: return 8'h45; 4'd11: return 8'h53;
         4'd12: return 8'h43; 4'd13: return 8'h55; 4'd14: return 8'h42; default: return 8'h38;
      endcase
   endfunction

   assign rom_data = rom_f(rom_addr);

   rom_streamer #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
      .abort(abort),
`ifdef STREAM_LOOP_EN
      .loop(loop),
`endif
      .rom_addr(rom_addr), .rom_data(rom_data), .char_out(char_out),
      .char_valid(char_valid), .char_ready(char_ready), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic kick(input logic [3:0] sa, input logic [4:0] ln);
      start_addr = sa;
      len        = ln;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   // Runs until busy drops, logging handshaked characters and done pulses.
   task automatic drain();
      int cyc = 0;
      got.delete();
      adrs.delete();
      n_done = 0; hs_cyc = -1; done_cyc = -1;
      while (busy && cyc < 300) begin
         if (char_valid && char_ready) begin
            got.push_back(char_out);
            adrs.push_back(rom_addr);
            hs_cyc = cyc;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      end_cyc = cyc;
      chk("drain_timeout", 32'(cyc < 300), 1);
   endtask

   initial begin
      int h;
      logic saw_done;
      rst = 1'b1; start = 1'b0; abort = 1'b0; char_ready = 1'b1;
      start_addr = '0; len = '0;
`ifdef STREAM_LOOP_EN
      loop = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", char_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_char", char_out, 0);
      chk("rst_addr", rom_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      // basic stream with latency check
      kick(4'd0, 5'd4);
      chk("lat_fetch_valid", char_valid, 0);
      chk("lat_fetch_busy", busy, 1);
      chk("lat_fetch_addr", rom_addr, 0);
      @(negedge clk);
      chk("lat_send_valid", char_valid, 1);
      chk("lat_send_char", char_out, 8'h53);
      drain();
      chk("s1_cnt", got.size(), 4);
      if (got.size() == 4) begin
         chk("s1_c0", got[0], 8'h53);
         chk("s1_c1", got[1], 8'h50);
         chk("s1_c2", got[2], 8'h41);
         chk("s1_c3", got[3], 8'h54);
      end
      chk("s1_ndone", n_done, 1);
      chk("s1_done_time", done_cyc, hs_cyc + 1);
      chk("s1_idle_time", end_cyc, done_cyc + 1);

      // address wrap 15 -> 0
      kick(4'd14, 5'd3);
      drain();
      chk("wrap_cnt", got.size(), 3);
      if (got.size() == 3) begin
         chk("wrap_c0", got[0], 8'h42);
         chk("wrap_c1", got[1], 8'h38);
         chk("wrap_c2", got[2], 8'h53);
         chk("wrap_a1", adrs[1], 4'd15);
         chk("wrap_a2", adrs[2], 4'd0);
      end

      // backpressure, with an ignored start in the middle
      char_ready = 1'b0;
      kick(4'd2, 5'd2);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid%0d", i), char_valid, 1);
         chk($sformatf("bp_char%0d", i), char_out, 8'h41);
         start      = (i == 2);
         start_addr = 4'd9;
         @(negedge clk);
      end
      start = 1'b0;
      char_ready = 1'b1;
      drain();
      chk("bp_cnt", got.size(), 2);
      if (got.size() == 2) chk("bp_c1", got[1], 8'h54);
      chk("bp_ndone", n_done, 1);
      repeat (2) @(negedge clk);
      chk("bp_stays_idle", busy, 0);

      // len=0 means a full 16-char pass
      kick(4'd5, 5'd0);
      drain();
      chk("full_cnt", got.size(), 16);
      if (got.size() == 16) begin
         chk("full_first", got[0], 8'h52);
         chk("full_last", got[15], 8'h41);
      end
      chk("full_ndone", n_done, 1);

      // abort in IDLE does not block a start
      abort = 1'b1;
      kick(4'd0, 5'd1);
      abort = 1'b0;
      chk("idle_abort_busy", busy, 1);
      drain();
      chk("idle_abort_cnt", got.size(), 1);
      chk("idle_abort_ndone", n_done, 1);

      // abort coincident with the third handshake
      kick(4'd0, 5'd8);
      h = 0;
      for (int c = 0; c < 50 && h < 3; c++) begin
         if (char_valid) h++;
         if (h == 3) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      chk("abort_hs", h, 3);
      chk("abort_busy", busy, 0);
      chk("abort_valid", char_valid, 0);
      chk("abort_done", done, 0);
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         saw_done |= done | busy;
      end
      chk("abort_quiet", saw_done, 0);

      // reset mid-stream
      kick(4'd0, 5'd8);
      repeat (3) @(negedge clk);
      chk("mid_pre_busy", busy, 1);
      chk("mid_pre_char", char_out, 8'h50);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", char_valid, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_char", char_out, 0);
      chk("mid_rst_addr", rom_addr, 0);
      @(negedge clk);
      chk("mid_rst_stays", busy, 0);

`ifdef STREAM_LOOP_EN
      loop = 1'b1;
      kick(4'd0, 5'd2);
      got.delete();
      n_done = 0;
      for (int c = 0; c < 100 && got.size() < 6; c++) begin
         if (char_valid && char_ready) got.push_back(char_out);
         if (done) n_done++;
         @(negedge clk);
      end
      chk("loop_cnt", got.size(), 6);
      if (got.size() == 6) begin
         chk("loop_c2", got[2], 8'h53);
         chk("loop_c5", got[5], 8'h50);
      end
      chk("loop_ndone", n_done, 2);
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      loop  = 1'b0;
      chk("loop_abort_busy", busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
